// File: rtl/clock_alarm_core.sv
// Alarm clock core: 1 Hz prescaler, BCD time of day in 24h form, field editor,
// 12h display mapping and an alarm sequencer with snooze and auto-silence.
//
// Alarm FSM states
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | alarm quiet, waiting for a tick that lands on alarm hh:mm:00
//   ST_RING   | Alarm_ring high, ring timer counting down seconds
//   ST_SNOOZE | alarm quiet, snooze timer counting down seconds to re-ring
module clock_alarm_core #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Set_en,
  input  logic [2:0] Set_sel,
  input  logic       Inc,
  input  logic       Dec,
  input  logic       Mode_12h,
  input  logic       Alarm_en,
  input  logic       Alarm_ack,
  input  logic       Snooze,
  output logic [7:0] Sec_bcd,
  output logic [7:0] Min_bcd,
  output logic [7:0] Hour_bcd,
  output logic       Pm,
  output logic [7:0] Alm_min_bcd,
  output logic [7:0] Alm_hour_bcd,
  output logic       Tick_1hz,
  output logic       Day_tick,
  output logic       Alarm_ring
);

  localparam int PRESC_W   = $clog2(TICK_DIV);
  localparam int SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int SNZ_W     = $clog2(SNZ_TICKS + 1);
  localparam int RING_W    = $clog2(RING_SEC + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [SNZ_W-1:0]   SNZ_LOAD   = SNZ_W'(SNZ_TICKS);
  localparam logic [SNZ_W-1:0]   SNZ_ONE    = SNZ_W'(1);
  localparam logic [RING_W-1:0]  RING_LOAD  = RING_W'(RING_SEC);
  localparam logic [RING_W-1:0]  RING_ONE   = RING_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } alarm_state_t;

  // Step a two-digit BCD value modulo 60 (seconds / minutes).
  function automatic logic [7:0] step60(input logic [7:0] v, input logic up);
    logic [3:0] t;
    logic [3:0] u;
    t = v[7:4];
    u = v[3:0];
    if (up) begin
      if (u == 4'd9) begin
        u = 4'd0;
        t = (t == 4'd5) ? 4'd0 : t + 4'd1;
      end else begin
        u = u + 4'd1;
      end
    end else begin
      if (u == 4'd0) begin
        u = 4'd9;
        t = (t == 4'd0) ? 4'd5 : t - 4'd1;
      end else begin
        u = u - 4'd1;
      end
    end
    return {t, u};
  endfunction

  // Step a two-digit BCD value modulo 24 (hours).
  function automatic logic [7:0] step24(input logic [7:0] v, input logic up);
    logic [3:0] t;
    logic [3:0] u;
    t = v[7:4];
    u = v[3:0];
    if (up) begin
      if (t == 4'd2 && u == 4'd3) begin
        t = 4'd0;
        u = 4'd0;
      end else if (u == 4'd9) begin
        t = t + 4'd1;
        u = 4'd0;
      end else begin
        u = u + 4'd1;
      end
    end else begin
      if (t == 4'd0 && u == 4'd0) begin
        t = 4'd2;
        u = 4'd3;
      end else if (u == 4'd0) begin
        t = t - 4'd1;
        u = 4'd9;
      end else begin
        u = u - 4'd1;
      end
    end
    return {t, u};
  endfunction

  logic [PRESC_W-1:0] presc_q;
  logic [7:0]         sec_q, min_q, hour_q;
  logic [7:0]         alm_min_q, alm_hour_q;
  logic               tick_q, day_q;

  alarm_state_t       state_q, state_d;
  logic [RING_W-1:0]  ring_cnt_q, ring_cnt_d;
  logic [SNZ_W-1:0]   snz_cnt_q, snz_cnt_d;

  logic               tick;
  logic               sec_wrap, min_wrap, hour_wrap;
  logic [7:0]         sec_nx, min_nx, hour_nx;
  logic               day_roll;
  logic               alarm_match;
  logic               edit_ok;

  logic [4:0]         hour_bin;
  logic [4:0]         hour_disp;
  logic [3:0]         hour_adj;

  assign tick      = !Set_en && (presc_q == PRESC_LAST);
  assign sec_wrap  = (sec_q == 8'h59);
  assign min_wrap  = (min_q == 8'h59);
  assign hour_wrap = (hour_q == 8'h23);

  assign sec_nx  = step60(sec_q, 1'b1);
  assign min_nx  = sec_wrap ? step60(min_q, 1'b1) : min_q;
  assign hour_nx = (sec_wrap && min_wrap) ? step24(hour_q, 1'b1) : hour_q;

  assign day_roll = tick && sec_wrap && min_wrap && hour_wrap;

  // A tick lands on hh:mm:00 exactly when seconds wrap, so only ticks can match.
  assign alarm_match = tick && sec_wrap && (min_nx == alm_min_q) && (hour_nx == alm_hour_q);

  assign edit_ok = Set_en && (Inc ^ Dec);

  // Prescaler: free-running 0..TICK_DIV-1, parked at 0 while editing.
  always_ff @(posedge Clk) begin
    if (Reset || Set_en) begin
      presc_q <= '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRESC_ONE;
    end
  end

  // Time-of-day and alarm registers: carry-chained on ticks, per-field edits otherwise.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sec_q      <= 8'h00;
      min_q      <= 8'h00;
      hour_q     <= 8'h00;
      alm_min_q  <= 8'h00;
      alm_hour_q <= 8'h00;
      tick_q     <= 1'b0;
      day_q      <= 1'b0;
    end else begin
      tick_q <= tick;
      day_q  <= day_roll;
      if (tick) begin
        sec_q  <= sec_nx;
        min_q  <= min_nx;
        hour_q <= hour_nx;
      end else if (edit_ok) begin
        case (Set_sel)
          3'd0:    sec_q      <= step60(sec_q, Inc);
          3'd1:    min_q      <= step60(min_q, Inc);
          3'd2:    hour_q     <= step24(hour_q, Inc);
          3'd3:    alm_min_q  <= step60(alm_min_q, Inc);
          3'd4:    alm_hour_q <= step24(alm_hour_q, Inc);
          default: ;
        endcase
      end
    end
  end

  assign hour_bin = ({1'b0, hour_q[7:4]} * 5'd10) + {1'b0, hour_q[3:0]};

  // Display hour: pass-through in 24h mode, 12/1..11 with PM flag in 12h mode.
  always_comb begin
    hour_disp = hour_bin;
    hour_adj  = 4'd0;
    Pm        = 1'b0;
    Hour_bcd  = hour_q;
    if (Mode_12h) begin
      Pm = (hour_bin >= 5'd12);
      if (hour_bin == 5'd0) begin
        hour_disp = 5'd12;
      end else if (hour_bin > 5'd12) begin
        hour_disp = hour_bin - 5'd12;
      end
      hour_adj = hour_disp[3:0] - 4'd10;
      Hour_bcd = (hour_disp >= 5'd10) ? {4'd1, hour_adj} : {4'd0, hour_disp[3:0]};
    end
  end

  // Alarm FSM state and its two second-timers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
    end
  end

  // Alarm FSM next state; disarm beats ack, ack beats snooze, both beat timeouts.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    if (!Alarm_en) begin
      state_d    = ST_IDLE;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (alarm_match) begin
            state_d    = ST_RING;
            ring_cnt_d = RING_LOAD;
          end
        end
        ST_RING: begin
          if (Alarm_ack) begin
            state_d    = ST_IDLE;
            ring_cnt_d = '0;
          end else if (Snooze) begin
            state_d    = ST_SNOOZE;
            ring_cnt_d = '0;
            snz_cnt_d  = SNZ_LOAD;
          end else if (tick) begin
            if (ring_cnt_q <= RING_ONE) begin
              state_d    = ST_IDLE;
              ring_cnt_d = '0;
            end else begin
              ring_cnt_d = ring_cnt_q - RING_ONE;
            end
          end
        end
        ST_SNOOZE: begin
          if (Alarm_ack) begin
            state_d   = ST_IDLE;
            snz_cnt_d = '0;
          end else if (tick) begin
            if (snz_cnt_q <= SNZ_ONE) begin
              state_d    = ST_RING;
              snz_cnt_d  = '0;
              ring_cnt_d = RING_LOAD;
            end else begin
              snz_cnt_d = snz_cnt_q - SNZ_ONE;
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          ring_cnt_d = '0;
          snz_cnt_d  = '0;
        end
      endcase
    end
  end

  assign Sec_bcd      = sec_q;
  assign Min_bcd      = min_q;
  assign Alm_min_bcd  = alm_min_q;
  assign Alm_hour_bcd = alm_hour_q;
  assign Tick_1hz     = tick_q;
  assign Day_tick     = day_q;
  assign Alarm_ring   = (state_q == ST_RING);

endmodule

// File: tb/tb_clock_alarm_core.sv
// Directed bench for clock_alarm_core with a small prescaler, 1-minute snooze
// and 3-second ring timeout. Expected snapshots are queued ahead of each step
// and compared against the DUT outputs on the following falling edge.
module tb_clock_alarm_core;

  localparam int TB_DIV  = 4;
  localparam int TB_SNZ  = 1;
  localparam int TB_RING = 3;
  localparam int SNZ_TICKS = TB_SNZ * 60;

  logic       Clk;
  logic       Reset;
  logic       Set_en;
  logic [2:0] Set_sel;
  logic       Inc, Dec, Mode_12h, Alarm_en, Alarm_ack, Snooze;
  logic [7:0] Sec_bcd, Min_bcd, Hour_bcd, Alm_min_bcd, Alm_hour_bcd;
  logic       Pm, Tick_1hz, Day_tick, Alarm_ring;

  int n_vec  = 0;
  int n_miss = 0;
  int tick_cnt = 0;

  logic [63:0] exp_q[$];
  string       tag_q[$];

  clock_alarm_core #(
    .TICK_DIV  (TB_DIV),
    .SNOOZE_MIN(TB_SNZ),
    .RING_SEC  (TB_RING)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Set_en      (Set_en),
    .Set_sel     (Set_sel),
    .Inc         (Inc),
    .Dec         (Dec),
    .Mode_12h    (Mode_12h),
    .Alarm_en    (Alarm_en),
    .Alarm_ack   (Alarm_ack),
    .Snooze      (Snooze),
    .Sec_bcd     (Sec_bcd),
    .Min_bcd     (Min_bcd),
    .Hour_bcd    (Hour_bcd),
    .Pm          (Pm),
    .Alm_min_bcd (Alm_min_bcd),
    .Alm_hour_bcd(Alm_hour_bcd),
    .Tick_1hz    (Tick_1hz),
    .Day_tick    (Day_tick),
    .Alarm_ring  (Alarm_ring)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) if (Tick_1hz === 1'b1) tick_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mk(input logic t, input logic d, input logic r, input logic p,
                                     input logic [7:0] ah, input logic [7:0] am,
                                     input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    return {20'b0, t, d, r, p, ah, am, h, m, s};
  endfunction

  function automatic logic [63:0] snap();
    return {20'b0, Tick_1hz, Day_tick, Alarm_ring, Pm, Alm_hour_bcd, Alm_min_bcd,
            Hour_bcd, Min_bcd, Sec_bcd};
  endfunction

  task automatic sb_push(input string tag, input logic [63:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_out(input logic [63:0] obs);
    logic [63:0] exp_v;
    string       tag;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      exp_v = exp_q.pop_front();
      tag   = tag_q.pop_front();
      assert (obs === exp_v) else begin
        n_miss++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
    end
  endtask

  // n single-cycle pulses on the selected field, one idle cycle between pulses.
  task automatic edit(input logic [2:0] sel, input logic inc, input logic dec, input int n);
    for (int i = 0; i < n; i++) begin
      Set_sel = sel;
      Inc = inc;
      Dec = dec;
      @(negedge Clk);
      Inc = 1'b0;
      Dec = 1'b0;
      @(negedge Clk);
    end
  endtask

  // Wait for n Tick_1hz pulses within a bounded number of cycles.
  task automatic wait_ticks(input int n, input string tag);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < n * TB_DIV + 8) begin
      @(negedge Clk);
      cyc++;
      if (Tick_1hz === 1'b1) seen++;
    end
    n_vec++;
    assert (seen == n) else begin
      n_miss++;
      $error("FAIL %s tick_count observed=%0d expected=%0d", tag, seen, n);
    end
  endtask

  initial begin
    int t0;
    Reset = 1'b1; Set_en = 1'b1; Set_sel = 3'd0; Inc = 1'b0; Dec = 1'b0;
    Mode_12h = 1'b0; Alarm_en = 1'b0; Alarm_ack = 1'b0; Snooze = 1'b0;

    // reset state
    sb_push("reset_hold", mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,8'h00));
    repeat (2) @(negedge Clk);
    check_out(snap());
    Reset = 1'b0;
    t0 = tick_cnt;

    // edit wrap, no carry, ignored combinations
    sb_push("min_dec_wrap", mk(0,0,0,0,8'h00,8'h00,8'h00,8'h59,8'h00));
    edit(3'd1, 1'b0, 1'b1, 1); check_out(snap());
    sb_push("inc_dec_both", mk(0,0,0,0,8'h00,8'h00,8'h00,8'h59,8'h00));
    edit(3'd1, 1'b1, 1'b1, 1); check_out(snap());
    sb_push("sel5_ignored", mk(0,0,0,0,8'h00,8'h00,8'h00,8'h59,8'h00));
    edit(3'd5, 1'b1, 1'b0, 1); check_out(snap());
    sb_push("hour_dec_wrap", mk(0,0,0,0,8'h00,8'h00,8'h23,8'h59,8'h00));
    edit(3'd2, 1'b0, 1'b1, 1); check_out(snap());
    sb_push("sec_dec_wrap", mk(0,0,0,0,8'h00,8'h00,8'h23,8'h59,8'h59));
    edit(3'd0, 1'b0, 1'b1, 1); check_out(snap());
    sb_push("sec_inc_nocarry", mk(0,0,0,0,8'h00,8'h00,8'h23,8'h59,8'h00));
    edit(3'd0, 1'b1, 1'b0, 1); check_out(snap());
    sb_push("preset_235958", mk(0,0,0,0,8'h00,8'h00,8'h23,8'h59,8'h58));
    edit(3'd0, 1'b0, 1'b1, 2); check_out(snap());
    n_vec++;
    assert (tick_cnt - t0 == 0) else begin
      n_miss++;
      $error("FAIL no_tick_in_set observed=%0d expected=0", tick_cnt - t0);
    end

    // rollover with 4-cycle tick period
    Set_en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i < 4)       sb_push("roll_pre",  mk(0,0,0,0,8'h00,8'h00,8'h23,8'h59,8'h58));
      else if (i == 4) sb_push("roll_t1",   mk(1,0,0,0,8'h00,8'h00,8'h23,8'h59,8'h59));
      else if (i < 8)  sb_push("roll_mid",  mk(0,0,0,0,8'h00,8'h00,8'h23,8'h59,8'h59));
      else             sb_push("roll_midnight", mk(1,1,0,0,8'h00,8'h00,8'h00,8'h00,8'h00));
      @(negedge Clk);
      check_out(snap());
    end
    Set_en = 1'b1;
    sb_push("day_tick_single", mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,8'h00));
    @(negedge Clk); check_out(snap());

    // 12h display
    Mode_12h = 1'b1;
    sb_push("h12_midnight", mk(0,0,0,0,8'h00,8'h00,8'h12,8'h00,8'h00));
    #1 check_out(snap());
    sb_push("h12_11am", mk(0,0,0,0,8'h00,8'h00,8'h11,8'h00,8'h00));
    edit(3'd2, 1'b1, 1'b0, 11); check_out(snap());
    sb_push("h12_noon", mk(0,0,0,1,8'h00,8'h00,8'h12,8'h00,8'h00));
    edit(3'd2, 1'b1, 1'b0, 1); check_out(snap());
    sb_push("h12_13", mk(0,0,0,1,8'h00,8'h00,8'h01,8'h00,8'h00));
    edit(3'd2, 1'b1, 1'b0, 1); check_out(snap());
    sb_push("h12_23", mk(0,0,0,1,8'h00,8'h00,8'h11,8'h00,8'h00));
    edit(3'd2, 1'b1, 1'b0, 10); check_out(snap());
    Mode_12h = 1'b0;
    sb_push("h24_23", mk(0,0,0,0,8'h00,8'h00,8'h23,8'h00,8'h00));
    #1 check_out(snap());

    // alarm 07:30, time 07:29:59, ring then snooze then re-ring then ack
    Alarm_en = 1'b1;
    edit(3'd4, 1'b1, 1'b0, 7);
    edit(3'd3, 1'b0, 1'b1, 30);
    edit(3'd2, 1'b1, 1'b0, 8);
    edit(3'd1, 1'b1, 1'b0, 29);
    sb_push("alarm_preset", mk(0,0,0,0,8'h07,8'h30,8'h07,8'h29,8'h59));
    edit(3'd0, 1'b0, 1'b1, 1); check_out(snap());
    Set_en = 1'b0;
    sb_push("alarm_ring", mk(1,0,1,0,8'h07,8'h30,8'h07,8'h30,8'h00));
    wait_ticks(1, "to_alarm"); check_out(snap());
    sb_push("snooze_quiet", mk(0,0,0,0,8'h07,8'h30,8'h07,8'h30,8'h00));
    Snooze = 1'b1; @(negedge Clk); Snooze = 1'b0; check_out(snap());
    sb_push("snooze_early", mk(1,0,0,0,8'h07,8'h30,8'h07,8'h30,8'h59));
    wait_ticks(SNZ_TICKS - 1, "snooze_run"); check_out(snap());
    sb_push("snooze_rering", mk(1,0,1,0,8'h07,8'h30,8'h07,8'h31,8'h00));
    wait_ticks(1, "snooze_end"); check_out(snap());
    sb_push("ack_idle", mk(0,0,0,0,8'h07,8'h30,8'h07,8'h31,8'h00));
    Alarm_ack = 1'b1; @(negedge Clk); Alarm_ack = 1'b0; Set_en = 1'b1; check_out(snap());

    // ring timeout
    edit(3'd1, 1'b0, 1'b1, 2);
    sb_push("timeout_preset", mk(0,0,0,0,8'h07,8'h30,8'h07,8'h29,8'h59));
    edit(3'd0, 1'b0, 1'b1, 1); check_out(snap());
    Set_en = 1'b0;
    sb_push("timeout_ring", mk(1,0,1,0,8'h07,8'h30,8'h07,8'h30,8'h00));
    wait_ticks(1, "to_alarm2"); check_out(snap());
    sb_push("timeout_still", mk(1,0,1,0,8'h07,8'h30,8'h07,8'h30,8'h02));
    wait_ticks(TB_RING - 1, "ring_run"); check_out(snap());
    sb_push("timeout_off", mk(1,0,0,0,8'h07,8'h30,8'h07,8'h30,8'h03));
    wait_ticks(1, "ring_end"); Set_en = 1'b1; check_out(snap());

    // ack and snooze together: ack wins
    edit(3'd1, 1'b0, 1'b1, 1);
    edit(3'd0, 1'b0, 1'b1, 4);
    Set_en = 1'b0;
    sb_push("prio_ring", mk(1,0,1,0,8'h07,8'h30,8'h07,8'h30,8'h00));
    wait_ticks(1, "to_alarm3"); check_out(snap());
    sb_push("prio_quiet", mk(0,0,0,0,8'h07,8'h30,8'h07,8'h30,8'h00));
    Alarm_ack = 1'b1; Snooze = 1'b1; @(negedge Clk);
    Alarm_ack = 1'b0; Snooze = 1'b0; check_out(snap());
    sb_push("prio_no_rering", mk(1,0,0,0,8'h07,8'h30,8'h07,8'h31,8'h00));
    wait_ticks(SNZ_TICKS, "prio_wait"); Set_en = 1'b1; check_out(snap());

    // disarm mid-snooze
    edit(3'd1, 1'b0, 1'b1, 2);
    edit(3'd0, 1'b0, 1'b1, 1);
    Set_en = 1'b0;
    sb_push("disarm_ring", mk(1,0,1,0,8'h07,8'h30,8'h07,8'h30,8'h00));
    wait_ticks(1, "to_alarm4"); check_out(snap());
    Snooze = 1'b1; @(negedge Clk); Snooze = 1'b0;
    wait_ticks(5, "snooze_part");
    sb_push("disarm_quiet", mk(0,0,0,0,8'h07,8'h30,8'h07,8'h30,8'h05));
    Alarm_en = 1'b0; @(negedge Clk); Alarm_en = 1'b1; check_out(snap());
    sb_push("disarm_no_rering", mk(1,0,0,0,8'h07,8'h30,8'h07,8'h31,8'h00));
    wait_ticks(SNZ_TICKS - 5, "disarm_wait"); check_out(snap());
    wait_ticks(5, "disarm_tail"); Set_en = 1'b1;

    // reset during RING
    edit(3'd1, 1'b0, 1'b1, 2);
    edit(3'd0, 1'b0, 1'b1, 6);
    Set_en = 1'b0;
    sb_push("reset_pre_ring", mk(1,0,1,0,8'h07,8'h30,8'h07,8'h30,8'h00));
    wait_ticks(1, "to_alarm5"); check_out(snap());
    sb_push("reset_in_ring", mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,8'h00));
    Reset = 1'b1; Set_en = 1'b1; @(negedge Clk); Reset = 1'b0; check_out(snap());

    // edit into alarm time: no ring
    edit(3'd3, 1'b1, 1'b0, 1);
    sb_push("edit_eq_alarm", mk(0,0,0,0,8'h00,8'h01,8'h00,8'h01,8'h00));
    edit(3'd1, 1'b1, 1'b0, 1); check_out(snap());
    Set_en = 1'b0;
    sb_push("edit_no_ring", mk(1,0,0,0,8'h00,8'h01,8'h00,8'h01,8'h02));
    wait_ticks(2, "after_edit"); check_out(snap());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/clock_alarm_core.md
CLOCK_ALARM_CORE -- requirements
Module: clock_alarm_core

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000: Clk cycles per second, legal range >= 2.
REQ-002 SHALL have parameter SNOOZE_MIN, default 5: snooze length in minutes, legal range 1..59.
REQ-003 SHALL have parameter RING_SEC, default 60: auto-silence timeout in seconds, legal range >= 1.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL provide the following ports, clock and reset first:
- Clk  in  1  system clock.
- Reset  in  1  synchronous active-high reset.
- Set_en  in  1  edit mode.
- Set_sel  in  3  field to edit: 0=sec, 1=min, 2=hour, 3=alarm min, 4=alarm hour; 5..7 select nothing.
- Inc  in  1  one-cycle increment pulse for the selected field.
- Dec  in  1  one-cycle decrement pulse for the selected field.
- Mode_12h  in  1  1 = 12-hour display.
- Alarm_en  in  1  alarm armed.
- Alarm_ack  in  1  one-cycle pulse: stop the alarm.
- Snooze  in  1  one-cycle pulse: snooze the alarm.
- Sec_bcd  out  8  seconds as two BCD digits.
- Min_bcd  out  8  minutes as two BCD digits.
- Hour_bcd  out  8  hours as two BCD digits.
- Pm  out  1  PM indicator.
- Alm_min_bcd  out  8  alarm minutes as two BCD digits.
- Alm_hour_bcd  out  8  alarm hours as two BCD digits, 24h.
- Tick_1hz  out  1  one-cycle second pulse.
- Day_tick  out  1  one-cycle midnight pulse.
- Alarm_ring  out  1  alarm sounding.

Function
REQ-006 SHALL run a prescaler 0..TICK_DIV-1; the tick cycle is the cycle with prescaler==TICK_DIV-1; prescaler wraps to 0 on that cycle.
REQ-007 SHALL, when Set_en=1, hold the prescaler at 0 with no ticks; counting resumes from 0 when Set_en falls.
REQ-008 SHALL hold time internally as BCD digits in 24h form; on each tick, sec+1 with carry sec 59->00 into min, min 59->00 into hour, hour 23->00.
REQ-009 SHALL drive Tick_1hz=1 in the cycle after each tick, coincident with the updated time on the outputs.
REQ-010 SHALL drive Day_tick=1 for one cycle, coincident with the 23:59:59->00:00:00 transition only.
REQ-011 SHALL, when Set_en=1 and exactly one of Inc/Dec is high, step the selected field by ±1 with wrap inside that field only.
- sec and min wrap 0..59; hour and alarm hour wrap 0..23; alarm min wraps 0..59.
- No carry or borrow into neighbouring fields.
- An edit never pulses Day_tick.
REQ-012 SHALL ignore Inc and Dec when both are high, when Set_en=0, or when Set_sel>=5.
REQ-013 SHALL produce display hours combinationally from the registered 24h hour:
- Mode_12h=0: Hour_bcd = 24h hour, Pm=0.
- Mode_12h=1: hour 0 shows 12 with Pm=0; 1..11 show 1..11 with Pm=0; 12 shows 12 with Pm=1; 13..23 show 1..11 with Pm=1.
REQ-014 SHALL implement an alarm FSM with states IDLE, RING, SNOOZE; Alarm_ring=1 only in RING.
REQ-015 SHALL generate a match event when a tick (REQ-008) produces hh:mm:00 equal to alarm hh:mm; edits that make time equal the alarm SHALL NOT generate a match.
REQ-016 SHALL make the following IDLE transition: IDLE->RING on a match with Alarm_en=1.
REQ-017 SHALL make the following RING transitions:
- Alarm_ack -> IDLE.
- else Snooze -> SNOOZE, loading the countdown with SNOOZE_MIN*60.
- else after RING_SEC ticks in RING -> IDLE.
REQ-018 SHALL make the following SNOOZE transitions:
- Countdown decrements on each tick.
- Countdown reaching 0 -> RING, restarting the RING_SEC count.
- Alarm_ack -> IDLE.
REQ-019 SHALL, when Alarm_en=0, force the FSM to IDLE on the next edge from any state; Alarm_ack takes priority over Snooze when both arrive in the same cycle.
REQ-020 SHALL keep ticks counted by the RING and SNOOZE timers frozen while Set_en=1, since no ticks occur.

Reset
REQ-021 SHALL, on Reset=1 at a Clk edge, set prescaler=0, time 00:00:00, alarm 00:00, FSM=IDLE, snooze and ring counters=0.
REQ-022 SHALL, during and after reset, hold Tick_1hz=0, Day_tick=0, Alarm_ring=0, Pm=0 and all BCD outputs 0x00.
REQ-023 SHALL give Reset priority over all inputs; a reset asserted mid-RING or mid-SNOOZE returns the FSM to IDLE with Alarm_ring=0 on the next cycle.

Verification
REQ-024 SHALL cover rollover: TICK_DIV=4, time preset to 23:59:58, run 8 cycles -> 23:59:59, then 00:00:00 with a single Day_tick pulse; Tick_1hz period is 4 cycles.
REQ-025 SHALL cover edit wrap: Set_en=1, Set_sel=1, min=00, Dec pulse -> min=59 with hour unchanged; Inc and Dec high together -> no change; no Tick_1hz while Set_en=1.
REQ-026 SHALL cover 12h display: hour=00 -> Hour_bcd 0x12, Pm=0; hour=12 -> 0x12, Pm=1; hour=13 -> 0x01, Pm=1; hour=23 -> 0x11, Pm=1.
REQ-027 SHALL cover alarm and snooze: alarm 07:30, Alarm_en=1, time 07:29:59, one tick -> Alarm_ring=1; Snooze -> ring=0; after SNOOZE_MIN*60 ticks -> ring=1; Alarm_ack -> IDLE.
REQ-028 SHALL cover timeout and priority: in RING with no input -> ring=0 after RING_SEC ticks; Alarm_ack and Snooze in the same cycle -> IDLE; Alarm_en=0 mid-SNOOZE -> IDLE next cycle.
REQ-029 SHALL cover reset: Reset asserted for 1 cycle during RING -> all outputs at reset values next cycle; setting time equal to the alarm via edit -> no ring.
